cpu_mem_access_ctrl: RTL and testbench



---
 rtl/cpu_mem_access_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cpu_mem_access_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_access_ctrl.sv
// Bus initiator between the CPU core and the test memory.
// Accepts one 8/16-bit read or write from the core, holds the memory request
// stable until the memory answers (or a timeout expires) and returns a
// one-cycle completion with error flag and read data to the core.

package pkg_cpu;
  localparam logic cpu_data_acc_sz_8  = 1'b0;
  localparam logic cpu_data_acc_sz_16 = 1'b1;
endpackage

module cpu_mem_access_ctrl #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_start,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic                  core_we,
  input  logic                  core_sz,
  input  logic [15:0]           core_wdata,
  output logic                  core_busy,
  output logic                  core_done,
  output logic                  core_err,
  output logic [15:0]           core_rdata,
  output logic                  mem_req_rdwr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_data_acc_sz,
  output logic [7:0]            mem_write_data_8,
  output logic [15:0]           mem_write_data_16,
  output logic                  mem_write_we_8,
  output logic                  mem_write_we_16,
  input  logic [7:0]            mem_read_data_8,
  input  logic [15:0]           mem_read_data_16,
  input  logic                  mem_data_ready
);

  // Counter is wide enough to hold TIMEOUT_CYCLES itself, so it never wraps
  // before the timeout compare fires.
  localparam int              CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  w_busy_nxt, w_done_nxt, w_err_nxt, w_req_nxt;
  logic                  w_we8_nxt, w_we16_nxt, w_sz_nxt;
  logic [15:0]           w_rdata_nxt, w_wd16_nxt;
  logic [7:0]            w_wd8_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  w_is_write;

  // A request is a write exactly when one of the latched write enables is set.
  assign w_is_write = mem_write_we_8 | mem_write_we_16;

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = core_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = core_err;
    w_rdata_nxt = core_rdata;
    w_req_nxt   = mem_req_rdwr;
    w_we8_nxt   = mem_write_we_8;
    w_we16_nxt  = mem_write_we_16;
    w_addr_nxt  = mem_addr;
    w_sz_nxt    = mem_data_acc_sz;
    w_wd8_nxt   = mem_write_data_8;
    w_wd16_nxt  = mem_write_data_16;
    case (r_state)
      S_IDLE: begin
        w_err_nxt = 1'b0;
        if (core_start) begin
          w_addr_nxt  = core_addr;
          w_sz_nxt    = core_sz;
          w_wd8_nxt   = core_wdata[7:0];
          w_wd16_nxt  = core_wdata;
          w_req_nxt   = 1'b1;
          w_we8_nxt   = core_we & (core_sz == pkg_cpu::cpu_data_acc_sz_8);
          w_we16_nxt  = core_we & (core_sz == pkg_cpu::cpu_data_acc_sz_16);
          w_cnt_nxt   = {CW{1'b0}};
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        w_cnt_nxt = r_cnt + CW'(1'b1);
        if (mem_data_ready) begin
          if (!w_is_write) begin
            w_rdata_nxt = (mem_data_acc_sz == pkg_cpu::cpu_data_acc_sz_8) ?
                          {8'h00, mem_read_data_8} : mem_read_data_16;
          end else begin
            w_rdata_nxt = core_rdata;
          end
          w_req_nxt   = 1'b0;
          w_we8_nxt   = 1'b0;
          w_we16_nxt  = 1'b0;
          w_err_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == C_LAST) begin
          w_req_nxt   = 1'b0;
          w_we8_nxt   = 1'b0;
          w_we16_nxt  = 1'b0;
          w_rdata_nxt = 16'h0000;
          w_err_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_req_nxt   = 1'b0;
        w_we8_nxt   = 1'b0;
        w_we16_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter and all outputs registered; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_cnt             <= {CW{1'b0}};
      core_busy         <= 1'b0;
      core_done         <= 1'b0;
      core_err          <= 1'b0;
      core_rdata        <= 16'h0000;
      mem_req_rdwr      <= 1'b0;
      mem_addr          <= {ADDR_WIDTH{1'b0}};
      mem_data_acc_sz   <= 1'b0;
      mem_write_data_8  <= 8'h00;
      mem_write_data_16 <= 16'h0000;
      mem_write_we_8    <= 1'b0;
      mem_write_we_16   <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_cnt             <= w_cnt_nxt;
      core_busy         <= w_busy_nxt;
      core_done         <= w_done_nxt;
      core_err          <= w_err_nxt;
      core_rdata        <= w_rdata_nxt;
      mem_req_rdwr      <= w_req_nxt;
      mem_addr          <= w_addr_nxt;
      mem_data_acc_sz   <= w_sz_nxt;
      mem_write_data_8  <= w_wd8_nxt;
      mem_write_data_16 <= w_wd16_nxt;
      mem_write_we_8    <= w_we8_nxt;
      mem_write_we_16   <= w_we16_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_mem_access_ctrl.sv
// Testbench for cpu_mem_access_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level model with a byte memory.

module tb_cpu_mem_access_ctrl;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_start;
  logic [15:0] core_addr;
  logic        core_we;
  logic        core_sz;
  logic [15:0] core_wdata;
  logic        core_busy;
  logic        core_done;
  logic        core_err;
  logic [15:0] core_rdata;
  logic        mem_req_rdwr;
  logic [15:0] mem_addr;
  logic        mem_data_acc_sz;
  logic [7:0]  mem_write_data_8;
  logic [15:0] mem_write_data_16;
  logic        mem_write_we_8;
  logic        mem_write_we_16;
  logic [7:0]  mem_read_data_8;
  logic [15:0] mem_read_data_16;
  logic        mem_data_ready;

  int n_pass  = 0;
  int n_total = 0;

  // model state
  logic [15:0] lat_addr;
  logic        lat_sz;
  logic [15:0] lat_wd;
  logic [15:0] exp_rdata;
  logic [7:0]  mem [logic [15:0]];

  cpu_mem_access_ctrl #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .reset             (reset),
    .core_start        (core_start),
    .core_addr         (core_addr),
    .core_we           (core_we),
    .core_sz           (core_sz),
    .core_wdata        (core_wdata),
    .core_busy         (core_busy),
    .core_done         (core_done),
    .core_err          (core_err),
    .core_rdata        (core_rdata),
    .mem_req_rdwr      (mem_req_rdwr),
    .mem_addr          (mem_addr),
    .mem_data_acc_sz   (mem_data_acc_sz),
    .mem_write_data_8  (mem_write_data_8),
    .mem_write_data_16 (mem_write_data_16),
    .mem_write_we_8    (mem_write_we_8),
    .mem_write_we_16   (mem_write_we_16),
    .mem_read_data_8   (mem_read_data_8),
    .mem_read_data_16  (mem_read_data_16),
    .mem_data_ready    (mem_data_ready)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] memrd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic chk_outs(input string ph, input logic req, input logic busy,
                          input logic done, input logic err,
                          input logic we8, input logic we16);
    check({ph, ".req"},   mem_req_rdwr,      req);
    check({ph, ".busy"},  core_busy,         busy);
    check({ph, ".done"},  core_done,         done);
    check({ph, ".err"},   core_err,          err);
    check({ph, ".we8"},   mem_write_we_8,    we8);
    check({ph, ".we16"},  mem_write_we_16,   we16);
    check({ph, ".rdata"}, core_rdata,        exp_rdata);
    check({ph, ".addr"},  mem_addr,          lat_addr);
    check({ph, ".sz"},    mem_data_acc_sz,   lat_sz);
    check({ph, ".wd8"},   mem_write_data_8,  lat_wd[7:0]);
    check({ph, ".wd16"},  mem_write_data_16, lat_wd);
  endtask

  // One complete transaction starting from IDLE. d = edge (counted from the
  // start edge) at which ready is sampled; d > T means the memory never answers.
  task automatic do_access(input logic we, input logic sz, input logic [15:0] addr,
                           input logic [15:0] wdata, input int d, input bit noise);
    int   fin;
    logic e8, e16, err;
    fin = (d <= T) ? d : T;
    err = (d > T);
    e8  = we & (sz == pkg_cpu::cpu_data_acc_sz_8);
    e16 = we & (sz == pkg_cpu::cpu_data_acc_sz_16);
    core_start     = 1'b1;
    core_we        = we;
    core_sz        = sz;
    core_addr      = addr;
    core_wdata     = wdata;
    mem_data_ready = noise ? 1'($urandom) : 1'b0;
    tick();
    lat_addr   = addr;
    lat_sz     = sz;
    lat_wd     = wdata;
    core_start = 1'b0;
    if (noise) begin
      core_addr  = 16'($urandom);
      core_wdata = 16'($urandom);
      core_we    = 1'($urandom);
      core_sz    = 1'($urandom);
    end
    chk_outs("start", 1'b1, 1'b1, 1'b0, 1'b0, e8, e16);
    for (int j = 1; j <= fin; j++) begin
      mem_data_ready   = (j == d);
      mem_read_data_8  = 8'($urandom);
      mem_read_data_16 = 16'($urandom);
      if (j == d) begin
        mem_read_data_8  = memrd(addr);
        mem_read_data_16 = {memrd(addr + 16'd1), memrd(addr)};
      end
      core_start = noise ? 1'($urandom) : 1'b0;
      tick();
      if (j < fin) begin
        chk_outs("access", 1'b1, 1'b1, 1'b0, 1'b0, e8, e16);
      end else begin
        if (err) begin
          exp_rdata = 16'h0000;
        end else if (we) begin
          mem[addr] = wdata[7:0];
          if (sz == pkg_cpu::cpu_data_acc_sz_16) mem[addr + 16'd1] = wdata[15:8];
        end else begin
          exp_rdata = (sz == pkg_cpu::cpu_data_acc_sz_16) ?
                      {memrd(addr + 16'd1), memrd(addr)} : {8'h00, memrd(addr)};
        end
        chk_outs("done", 1'b0, 1'b1, 1'b1, err, 1'b0, 1'b0);
      end
    end
    // DONE cycle: start and ready must both be ignored here
    mem_data_ready = noise ? 1'($urandom) : 1'b0;
    core_start     = noise;
    tick();
    chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    core_start     = 1'b0;
    mem_data_ready = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    core_start       = 1'b0;
    core_addr        = 16'h0000;
    core_we          = 1'b0;
    core_sz          = 1'b0;
    core_wdata       = 16'h0000;
    mem_read_data_8  = 8'h00;
    mem_read_data_16 = 16'h0000;
    mem_data_ready   = 1'b0;
    lat_addr         = 16'h0000;
    lat_sz           = 1'b0;
    lat_wd           = 16'h0000;
    exp_rdata        = 16'h0000;
    mem[16'h0010]    = 8'hA5;
    mem[16'h0011]    = 8'h5A;
    mem[16'h0030]    = 8'h3C;
    mem[16'hFFFF]    = 8'h12;
    mem[16'h0000]    = 8'h34;

    // reset state
    tick();
    tick();
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 8-bit read of A5
    do_access(1'b0, pkg_cpu::cpu_data_acc_sz_8, 16'h0010, 16'h0000, 3, 1'b0);
    check("rd8_a5", core_rdata, 16'h00A5);

    // 16-bit write BEEF then 16-bit read back (back-to-back)
    do_access(1'b1, pkg_cpu::cpu_data_acc_sz_16, 16'h0020, 16'hBEEF, 2, 1'b0);
    do_access(1'b0, pkg_cpu::cpu_data_acc_sz_16, 16'h0020, 16'h0000, 1, 1'b0);
    check("rd16_beef", core_rdata, 16'hBEEF);

    // memory never answers: timeout
    do_access(1'b0, pkg_cpu::cpu_data_acc_sz_16, 16'h0010, 16'h0000, 100, 1'b0);
    check("timeout_rdata", core_rdata, 16'h0000);

    // start pulses during ACCESS and DONE are ignored
    do_access(1'b0, pkg_cpu::cpu_data_acc_sz_16, 16'h0010, 16'h0000, 5, 1'b1);
    check("noise_rd16", core_rdata, 16'h5AA5);

    // ready on the same cycle as the timeout: ready wins
    do_access(1'b0, pkg_cpu::cpu_data_acc_sz_8, 16'h0030, 16'h0000, T, 1'b0);
    check("ready_at_limit", core_rdata, 16'h003C);

    // 16-bit read at FFFF: address passed unchanged
    do_access(1'b0, pkg_cpu::cpu_data_acc_sz_16, 16'hFFFF, 16'h0000, 2, 1'b0);
    check("wrap_rd16", core_rdata, 16'h3412);

    // reset in the second ACCESS cycle of a write
    core_start = 1'b1;
    core_we    = 1'b1;
    core_sz    = pkg_cpu::cpu_data_acc_sz_16;
    core_addr  = 16'h0040;
    core_wdata = 16'hCAFE;
    tick();
    lat_addr   = 16'h0040;
    lat_sz     = pkg_cpu::cpu_data_acc_sz_16;
    lat_wd     = 16'hCAFE;
    core_start = 1'b0;
    chk_outs("rst_wr_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_outs("rst_wr_acc", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    lat_addr  = 16'h0000;
    lat_sz    = 1'b0;
    lat_wd    = 16'h0000;
    exp_rdata = 16'h0000;
    chk_outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset          = 1'b0;
    mem_data_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_outs("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    mem_data_ready = 1'b0;
    do_access(1'b0, pkg_cpu::cpu_data_acc_sz_8, 16'h0030, 16'h0000, 2, 1'b0);
    check("rst_rd8", core_rdata, 16'h003C);

    // randomized transactions against the model
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 9) == 0) ? 16'hFFFF : (16'h0100 + 16'($urandom_range(0, 15)));
      do_access(1'($urandom), 1'($urandom), a, 16'($urandom),
                $urandom_range(1, T + 3), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
